// File: rtl/cia_sp_peer_if.sv
// ---------------------------------------------------------------------------
// cia_sp_peer_if
// Byte-level host side of the serial-port peer.
//   tx_data/tx_valid/tx_ready : byte to shift out towards the SoC (valid/ready)
//   rx_data/rx_valid/rx_ack   : last byte received from the SoC (sticky valid)
//   rx_overrun/rx_ovr_clr     : sticky overrun flag and its clear strobe
// master = host logic driving the peer, slave = the peer itself.
// ---------------------------------------------------------------------------
interface cia_sp_peer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       rx_overrun;
   logic       rx_ovr_clr;

   modport master (
      output tx_data, tx_valid, rx_ack, rx_ovr_clr,
      input  tx_ready, rx_data, rx_valid, rx_overrun
   );

   modport slave (
      input  tx_data, tx_valid, rx_ack, rx_ovr_clr,
      output tx_ready, rx_data, rx_valid, rx_overrun
   );
endinterface

// File: rtl/cia_sp_peer.sv
// ---------------------------------------------------------------------------
// cia_sp_peer
// Off-chip partner for a 6526-style serial port (the far end of SP/CNT).
// Transmits bytes into the SoC generating CNT itself, and receives bytes the
// SoC shifts out. MSB first, data sampled on CNT rising edges, full duplex.
// Ports:
//   clk, reset_n      : system clock, asynchronous active-low reset
//   cnt_in, sp_in     : CNT / data from the SoC (asynchronous)
//   cnt_out, sp_out   : generated CNT / data towards the SoC
//   host              : byte-level TX valid/ready and RX sticky valid/ack
// Parameters:
//   CNT_DIV    : clk cycles per CNT half-period when transmitting (2..255)
//   RX_TIMEOUT : idle clk cycles mid-byte before a partial byte is dropped
// ---------------------------------------------------------------------------
module cia_sp_peer #(
   parameter int CNT_DIV    = 8,
   parameter int RX_TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         cnt_in,
   input  logic         sp_in,
   output logic         cnt_out,
   output logic         sp_out,
   cia_sp_peer_if.slave host
);

   localparam logic [7:0]        DIV_LAST  = 8'(CNT_DIV - 1);
   localparam int                IDLE_W    = $clog2(RX_TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RX_TIMEOUT - 1);

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {TX_IDLE, TX_LOW, TX_HIGH, TX_GAP} tx_state_t;

   tx_state_t  tx_state, tx_state_nxt;
   logic [7:0] tx_timer, tx_timer_nxt;
   logic [7:0] tx_shift, tx_shift_nxt;
   logic [2:0] tx_bits,  tx_bits_nxt;
   logic       cnt_nxt,  sp_nxt;
   logic       period_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state <= TX_IDLE;
         tx_timer <= '0;
         tx_shift <= '0;
         tx_bits  <= '0;
         cnt_out  <= 1'b1;
         sp_out   <= 1'b1;
      end else begin
         tx_state <= tx_state_nxt;
         tx_timer <= tx_timer_nxt;
         tx_shift <= tx_shift_nxt;
         tx_bits  <= tx_bits_nxt;
         cnt_out  <= cnt_nxt;
         sp_out   <= sp_nxt;
      end
   end

   assign period_done   = (tx_timer == DIV_LAST);
   assign host.tx_ready = (tx_state == TX_IDLE);

   // cnt_out/sp_out are registered, so each state sets them for the state
   // being entered; the LOW->HIGH transition is the SoC's sample point.
   always_comb begin
      tx_state_nxt = tx_state;
      tx_timer_nxt = tx_timer;
      tx_shift_nxt = tx_shift;
      tx_bits_nxt  = tx_bits;
      cnt_nxt      = cnt_out;
      sp_nxt       = sp_out;
      unique case (tx_state)
         TX_IDLE: begin
            cnt_nxt = 1'b1;
            sp_nxt  = 1'b1;
            if (host.tx_valid) begin
               tx_state_nxt = TX_LOW;
               tx_timer_nxt = '0;
               tx_shift_nxt = host.tx_data;
               tx_bits_nxt  = '0;
               cnt_nxt      = 1'b0;
               sp_nxt       = host.tx_data[7];
            end
         end
         TX_LOW: begin
            if (period_done) begin
               tx_state_nxt = TX_HIGH;
               tx_timer_nxt = '0;
               cnt_nxt      = 1'b1;
            end else begin
               tx_timer_nxt = tx_timer + 8'd1;
            end
         end
         TX_HIGH: begin
            if (period_done) begin
               tx_timer_nxt = '0;
               tx_shift_nxt = {tx_shift[6:0], 1'b0};
               if (tx_bits == 3'd7) begin
                  tx_state_nxt = TX_GAP;
                  tx_bits_nxt  = '0;
                  sp_nxt       = 1'b1;
               end else begin
                  tx_state_nxt = TX_LOW;
                  tx_bits_nxt  = tx_bits + 3'd1;
                  cnt_nxt      = 1'b0;
                  sp_nxt       = tx_shift[6];
               end
            end else begin
               tx_timer_nxt = tx_timer + 8'd1;
            end
         end
         TX_GAP: begin
            if (period_done) begin
               tx_state_nxt = TX_IDLE;
               tx_timer_nxt = '0;
            end else begin
               tx_timer_nxt = tx_timer + 8'd1;
            end
         end
         default: begin
            tx_state_nxt = TX_IDLE;
            tx_timer_nxt = '0;
            cnt_nxt      = 1'b1;
            sp_nxt       = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   logic [2:0]        cnt_sync;
   logic [1:0]        sp_sync;
   logic [7:0]        rx_shift;
   logic [3:0]        rx_bits;
   logic [IDLE_W-1:0] rx_idle;
   logic              cnt_rise;
   logic              byte_done;
   logic              rx_timeout;
   logic              new_overrun;

   // Preset to 1 so an idle-high line never looks like an edge after reset.
   // sp has the same depth as the cnt stage used for the edge, keeping the
   // two aligned when the SoC changes them close together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_sync <= 3'b111;
         sp_sync  <= 2'b11;
      end else begin
         cnt_sync <= {cnt_sync[1:0], cnt_in};
         sp_sync  <= {sp_sync[0], sp_in};
      end
   end

   assign cnt_rise    = cnt_sync[1] & ~cnt_sync[2];
   assign byte_done   = (rx_bits == 4'd8);
   assign rx_timeout  = (rx_bits != 4'd0) && !byte_done && !cnt_rise &&
                        (rx_idle == IDLE_LAST);
   assign new_overrun = byte_done & host.rx_valid & ~host.rx_ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_shift <= '0;
         rx_bits  <= '0;
      end else if (byte_done) begin
         rx_bits  <= '0;
      end else if (cnt_rise) begin
         rx_shift <= {rx_shift[6:0], sp_sync[1]};
         rx_bits  <= rx_bits + 4'd1;
      end else if (rx_timeout) begin
         rx_bits  <= '0;
      end
   end

   // Idle counter only runs while a byte is partially assembled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_idle <= '0;
      end else if (rx_bits == 4'd0 || byte_done || cnt_rise || rx_timeout) begin
         rx_idle <= '0;
      end else begin
         rx_idle <= rx_idle + 1'b1;
      end
   end

   // A completing byte beats a same-cycle ack, and a new overrun beats a
   // same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         host.rx_data    <= '0;
         host.rx_valid   <= 1'b0;
         host.rx_overrun <= 1'b0;
      end else begin
         if (byte_done) begin
            host.rx_data <= rx_shift;
         end
         host.rx_valid   <= byte_done | (host.rx_valid & ~host.rx_ack);
         host.rx_overrun <= new_overrun | (host.rx_overrun & ~host.rx_ovr_clr);
      end
   end

endmodule

// File: doc/cia_sp_peer.md
Name: cia_sp_peer

Overview:
- Off-chip partner for the SoC's 6526-style serial port, i.e. the other end of the SP/CNT link.
- Receives bytes the SoC shifts out on sp_out/cnt_out and transmits bytes into the SoC's sp_in/cnt_in, generating CNT itself.
- Used in benches and on-board loopback to exercise the serial port in both directions.
- Byte-level host side: valid/ready for TX, sticky valid/ack for RX.

Parameters:
- CNT_DIV, 8: clk cycles per CNT half-period when transmitting; legal range 2..255.
- RX_TIMEOUT, 1024: clk cycles without a CNT rising edge mid-byte before the RX bit counter is discarded; must be > 0.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cnt_in  input  1  CNT from SoC (SoC cnt_out); asynchronous
- sp_in  input  1  serial data from SoC (SoC sp_out); asynchronous
- cnt_out  output  1  generated CNT to SoC cnt_in
- sp_out  output  1  serial data to SoC sp_in
- tx_data  input  8  byte to transmit
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  transmitter idle, accepts a byte
- rx_data  output  8  last received byte
- rx_valid  output  1  unread byte present (sticky)
- rx_ack  input  1  host consumed rx_data
- rx_overrun  output  1  byte completed while rx_valid was high (sticky)
- rx_ovr_clr  input  1  clears rx_overrun

Behaviour:
- Reset (async assert, sync release): cnt_out=1, sp_out=1, tx_ready=1, rx_data=0x00, rx_valid=0, rx_overrun=0. Synchronizers are preset to 1. Bit counters are 0. TX FSM is in IDLE.
- Bit order is MSB first, 8 bits per byte, in both directions. Data is sampled on CNT rising edges.
- TX FSM states: IDLE, LOW, HIGH, GAP.
  - IDLE: tx_ready=1, cnt_out=1. On tx_valid&tx_ready, latch tx_data, set bit count=0, go to LOW next cycle, tx_ready=0.
  - LOW: cnt_out=0 and sp_out=current MSB, both registered and updated on entry. Lasts CNT_DIV cycles, then HIGH.
  - HIGH: cnt_out=1 and sp_out held; the rising edge is the SoC sample point. Lasts CNT_DIV cycles. Then shift left and increment the count. If 8 bits have been sent go to GAP, else LOW.
  - GAP: cnt_out=1, sp_out=1 for CNT_DIV cycles, then IDLE.
  - A byte occupies 17*CNT_DIV cycles from the accept edge to tx_ready rising.
  - tx_valid while tx_ready=0 is ignored; tx_data is only sampled at accept.
- RX:
  - cnt_in and sp_in each pass through 2-flop synchronizers. A third cnt stage provides rising-edge detect.
  - On a detected rising edge, shift in the synchronized sp_in (same pipeline depth as cnt, so skew-aligned) and increment the count.
  - On the 8th bit, the next cycle: rx_data=assembled byte, count=0, rx_valid=1. If rx_valid was already 1 and not being acked that same cycle, set rx_overrun=1 and overwrite rx_data.
  - rx_ack clears rx_valid. A completion in the same cycle as rx_ack wins: rx_valid stays 1, no overrun.
  - rx_ovr_clr clears rx_overrun. A simultaneous new overrun wins.
  - Timeout: while count≠0, an idle counter runs and is cleared on each edge. When it reaches RX_TIMEOUT, count=0 and the partial byte is dropped silently.
  - The CNT low/high minimum is 2 clk (synchronizer limit). Faster CNT is unsupported.
- RX and TX are independent; full duplex is allowed.
- Reset mid-byte (either direction) aborts immediately; no partial byte is delivered.

Test Plan:
- TX 0xA5, CNT_DIV=4 -> cnt_out shows 8 low/high pulses of 4 clk each. sp_out sampled at rising edges = 1,0,1,0,0,1,0,1. tx_ready returns 68 clk after accept.
- Drive cnt_in/sp_in with 0x3C (half-period 5 clk) -> rx_data=0x3C, rx_valid=1 until rx_ack, rx_overrun=0.
- Two bytes 0x11 then 0x22 with no rx_ack -> rx_data=0x22, rx_overrun=1. rx_ovr_clr -> rx_overrun=0.
- 3 bits sent, then idle > RX_TIMEOUT, then full 0x81 -> rx_data=0x81 (partial bits discarded).
- Loopback cnt_out->cnt_in and sp_out->sp_in, TX 0x5A -> rx_data=0x5A, rx_valid=1. tx_valid held high during transmission -> exactly one byte sent.
- reset_n low during bit 4 of TX -> cnt_out=1, sp_out=1, tx_ready=1 asynchronously; rx_valid=0.
